gtp_frame_check: RTL and testbench
==================================

Name: gtp_frame_check

Overview:
Per-channel frame checker on the CLK125 side, directly upstream of rcvfifo. It sits between one 16-bit lane of the GTP receiver (data_o/charisk_o) and that lane's rcvfifo gtp_dat/gtp_vld inputs. It parses channel-FPGA frames, verifies length and checksum, and forwards header and payload words. The checksum word is replaced by a status word, so software reading the fifo sees a per-frame verdict. It also keeps saturating error counters for the regA..regD style status registers.

Parameters:
MAXLEN, 1023, largest accepted payload length in words; headers with a larger length field are rejected.
CNTW, 16, width of each saturating counter.

Ports:
clk  input  1  GTP recovered 125 MHz clock (CLK125).
rst  input  1  asynchronous, active-high reset.
gtp_dat  input  16  received lane word.
gtp_kchar  input  1  1 = word is a K-character (idle/comma/clock correction).
dat_o  output  16  word to rcvfifo gtp_dat.
vld_o  output  1  dat_o valid; drives rcvfifo gtp_vld.
cnt_ok  output  CNTW  frames closed with status all-clear.
cnt_bad  output  CNTW  frames closed with any error flag, plus rejected headers.
cnt_stray  output  CNTW  non-K words discarded outside a frame.
cnt_clr  input  1  synchronous clear of all three counters.

Behaviour:
- Word classes (non-K only; K words are ignored in every state and never forwarded or counted):
  - Header: [15:14]=10, [13:10] source id, [9:0] length L.
  - Payload: [15]=0.
  - Checksum: any 16-bit value.
- Status word emitted: [15:14]=11, [13] csum_err, [12] len_err, [11] bit15_err, [10] 0, [9:0] payload words forwarded.
- Latency: every forwarded or generated word appears on dat_o/vld_o exactly 1 clk after its input. dat_o and vld_o are registered. vld_o is high for one cycle per word.
- Running checksum: 16-bit XOR of the header and all payload words as received, before masking.
- State machine IDLE / PAYLOAD / CSUM:
  - IDLE, header with L<=MAXLEN: forward header, load remaining=L, init XOR=header, clear flags and count. Go to PAYLOAD if L>0, else CSUM.
  - IDLE, header with L>MAXLEN: not forwarded, cnt_bad+1, stay IDLE.
  - IDLE, any other non-K word: discarded, cnt_stray+1.
  - PAYLOAD, word [15]=0: forward, XOR accumulate, count+1, remaining-1. Go to CSUM when remaining reaches 0.
  - PAYLOAD, word [15:14]=11: forward with [15] forced 0, set bit15_err, otherwise treated as payload.
  - PAYLOAD, word [15:14]=10 (truncation): emit status with len_err=1 and current count, cnt_bad+1, go to IDLE. The truncating header is consumed and not accepted; the following words of that frame count as stray.
  - CSUM, any non-K word: compare with XOR; csum_err = mismatch. Emit status, increment cnt_ok if all flags are 0, else cnt_bad. Go to IDLE.
- Counters saturate at all-ones, no wrap.
- cnt_clr has priority over a same-cycle increment; the counter reads 0 next cycle.
- Reset: state IDLE, dat_o=0, vld_o=0, all counters 0, XOR/count/flags 0.
- Reset asserted mid-frame: the partial frame is abandoned with no status word. After release, words until the next header are stray.

Decomposition:
Shared package gtp_frame_pkg holds:
- header/status tag constants (2'b10, 2'b11);
- status bit positions;
- length field width (10);
- state encoding.

One sub-module, sat_counter (CNTW-bit, inc, clr, saturating), instantiated three times. Everything else stays flat.

Test Plan:
1. Good frame: 0x8403, 0x0001, 0x0002, 0x0004, csum 0x8404 (with K words interleaved) -> dat_o sequence 0x8403, 0x0001, 0x0002, 0x0004, 0xC003, each 1 clk after input; cnt_ok=1.
2. Bad checksum: same frame with csum 0x0000 -> last word 0xE003; cnt_bad=1, cnt_ok=0.
3. Truncation: 0x8403, 0x0001, then header 0x8802 -> status 0xD001; 0x8802 not forwarded; its next two payload words give cnt_stray=2, cnt_bad=1.
4. Bit15 violation and zero length:
   - 0x8401, 0xC005, csum 0x4404 -> 0x8401, 0x4005, 0xC801.
   - 0x8000, csum 0x8000 -> 0x8000, 0xC000, cnt_ok+1.
5. Oversize header, saturation and clear:
   - with MAXLEN=16, header 0x8011 -> nothing forwarded, cnt_bad+1.
   - 65536 stray words -> cnt_stray=0xFFFF held.
   - cnt_clr together with a stray word -> 0.
6. Async reset mid-payload -> vld_o=0 immediately, no status word; after release, payload words count as stray until next header.

Source files
------------

// File: rtl/gtp_frame_check_pkg.sv
// Shared definitions for the GTP lane frame checker.
// Holds the word-tag constants, status word bit positions, the length
// field width, the checker state encoding and a status word builder.
package gtp_frame_pkg;

  // Top two bits of a header word and of a generated status word.
  localparam logic [1:0] TAG_HDR = 2'b10;
  localparam logic [1:0] TAG_STS = 2'b11;

  // Width of the header length field and of the forwarded-word count.
  localparam int LEN_W = 10;

  // Status word flag positions.
  localparam int STS_CSUM_BIT = 13;
  localparam int STS_LEN_BIT  = 12;
  localparam int STS_B15_BIT  = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PAYLOAD = 2'b01,
    ST_CSUM    = 2'b10
  } state_e;

  // Assemble a status word: tag, three error flags, a reserved zero bit
  // and the number of payload words forwarded for the frame.
  function automatic logic [15:0] make_status(input logic             csum_err,
                                              input logic             len_err,
                                              input logic             b15_err,
                                              input logic [LEN_W-1:0] count);
    logic [15:0] sts;
    sts               = {TAG_STS, 4'b0000, count};
    sts[STS_CSUM_BIT] = csum_err;
    sts[STS_LEN_BIT]  = len_err;
    sts[STS_B15_BIT]  = b15_err;
    return sts;
  endfunction

endpackage

// File: rtl/gtp_frame_check_if.sv
// Lane interface between the GTP receiver side and the rcvfifo side.
//   gtp_dat / gtp_kchar : received lane word and its K-character flag
//   dat_o / vld_o       : checked word towards rcvfifo and its valid strobe
// master = the word source / fifo side, slave = the frame checker.
interface gtp_frame_check_if;
  logic [15:0] gtp_dat;
  logic        gtp_kchar;
  logic [15:0] dat_o;
  logic        vld_o;

  modport master (output gtp_dat, output gtp_kchar, input dat_o, input vld_o);
  modport slave  (input gtp_dat, input gtp_kchar, output dat_o, output vld_o);
endinterface

// File: rtl/gtp_frame_check_sat_counter.sv
// Saturating event counter.
//   clk, rst : clock and asynchronous active-high reset
//   inc_i    : count one event this cycle
//   clr_i    : synchronous clear, wins over a same-cycle increment
//   cnt_o    : current count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gtp_frame_check.sv
// Per-lane frame checker sitting directly upstream of rcvfifo.
// Parses header / payload / checksum frames from one 16-bit GTP lane,
// forwards header and payload words, replaces the checksum word with a
// status word carrying the frame verdict, and counts good, bad and stray
// traffic in saturating counters.
//   clk, rst   : CLK125 and asynchronous active-high reset
//   lane       : gtp_dat/gtp_kchar in, dat_o/vld_o out (registered, 1 clk)
//   cnt_ok     : frames closed with no error flag
//   cnt_bad    : frames closed with an error flag, plus rejected headers
//   cnt_stray  : non-K words discarded outside a frame
//   cnt_clr    : synchronous clear of all three counters
module gtp_frame_check
  import gtp_frame_pkg::*;
#(
  parameter int MAXLEN = 1023,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  gtp_frame_check_if.slave lane,
  output logic [CNTW-1:0] cnt_ok,
  output logic [CNTW-1:0] cnt_bad,
  output logic [CNTW-1:0] cnt_stray,
  input  logic            cnt_clr
);

  localparam logic [31:0] MAXLEN_U = 32'(MAXLEN);

  state_e            state_q;
  logic [15:0]       dat_q;
  logic              vld_q;
  logic [15:0]       xor_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  remain_q;
  logic              b15_err_q;

  logic [15:0]       word_s;
  logic              is_data_s;
  logic              is_hdr_s;
  logic [LEN_W-1:0]  hdr_len_s;
  logic              len_ok_s;
  logic              csum_err_s;
  logic              inc_ok_s;
  logic              inc_bad_s;
  logic              inc_stray_s;

  assign word_s     = lane.gtp_dat;
  assign is_data_s  = ~lane.gtp_kchar;
  assign is_hdr_s   = (word_s[15:14] == TAG_HDR);
  assign hdr_len_s  = word_s[LEN_W-1:0];
  assign len_ok_s   = ({22'd0, hdr_len_s} <= MAXLEN_U);
  assign csum_err_s = (word_s != xor_q);

  // Counter event decode from the current state and the incoming word.
  always_comb begin
    inc_ok_s    = 1'b0;
    inc_bad_s   = 1'b0;
    inc_stray_s = 1'b0;
    if (is_data_s) begin
      case (state_q)
        ST_IDLE: begin
          if (is_hdr_s) begin
            inc_bad_s = ~len_ok_s;
          end else begin
            inc_stray_s = 1'b1;
          end
        end
        // A header arriving mid-payload truncates the frame.
        ST_PAYLOAD: inc_bad_s = is_hdr_s;
        ST_CSUM: begin
          if (csum_err_s || b15_err_q) begin
            inc_bad_s = 1'b1;
          end else begin
            inc_ok_s = 1'b1;
          end
        end
        default: inc_stray_s = 1'b0;
      endcase
    end else begin
      inc_ok_s    = 1'b0;
      inc_bad_s   = 1'b0;
      inc_stray_s = 1'b0;
    end
  end

  // Frame state machine with registered output word and valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dat_q     <= 16'h0000;
      vld_q     <= 1'b0;
      xor_q     <= 16'h0000;
      count_q   <= '0;
      remain_q  <= '0;
      b15_err_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (is_data_s) begin
        case (state_q)
          ST_IDLE: begin
            if (is_hdr_s && len_ok_s) begin
              dat_q     <= word_s;
              vld_q     <= 1'b1;
              xor_q     <= word_s;
              count_q   <= '0;
              remain_q  <= hdr_len_s;
              b15_err_q <= 1'b0;
              state_q   <= (hdr_len_s != '0) ? ST_PAYLOAD : ST_CSUM;
            end
          end
          ST_PAYLOAD: begin
            if (is_hdr_s) begin
              // Truncating header is consumed; close the frame with len_err.
              dat_q   <= make_status(1'b0, 1'b1, b15_err_q, count_q);
              vld_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              // Only a 2'b11 word reaches here with bit 15 set; mask it but
              // keep the raw word in the checksum.
              dat_q    <= {1'b0, word_s[14:0]};
              vld_q    <= 1'b1;
              xor_q    <= xor_q ^ word_s;
              count_q  <= count_q + LEN_W'(1);
              remain_q <= remain_q - LEN_W'(1);
              if (word_s[15]) begin
                b15_err_q <= 1'b1;
              end
              if (remain_q == LEN_W'(1)) begin
                state_q <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            dat_q   <= make_status(csum_err_s, 1'b0, b15_err_q, count_q);
            vld_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign lane.dat_o = dat_q;
  assign lane.vld_o = vld_q;

  sat_counter #(.W(CNTW)) u_cnt_ok (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_ok_s),
    .clr_i (cnt_clr),
    .cnt_o (cnt_ok)
  );

  sat_counter #(.W(CNTW)) u_cnt_bad (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_bad_s),
    .clr_i (cnt_clr),
    .cnt_o (cnt_bad)
  );

  sat_counter #(.W(CNTW)) u_cnt_stray (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_stray_s),
    .clr_i (cnt_clr),
    .cnt_o (cnt_stray)
  );

endmodule

// File: tb/tb_gtp_frame_check.sv
// Self-checking bench for gtp_frame_check: expected output words are queued
// with their due cycle as stimulus is driven and compared when vld_o fires.
`timescale 1ns/1ps
module tb_gtp_frame_check;
  localparam int CNTW   = 16;
  localparam int MAXLEN = 16;
  localparam logic [15:0] KIDLE = 16'h50BC;

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cnt_clr = 1'b0;
  logic [CNTW-1:0] cnt_ok, cnt_bad, cnt_stray;
  int unsigned     cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  exp_t            sb_q[$];

  gtp_frame_check_if lane_if();

  gtp_frame_check #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .lane      (lane_if),
    .cnt_ok    (cnt_ok),
    .cnt_bad   (cnt_bad),
    .cnt_stray (cnt_stray),
    .cnt_clr   (cnt_clr)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] w, input logic k, input logic exp_v, input logic [15:0] exp_w);
    @(negedge clk);
    lane_if.gtp_dat   = w;
    lane_if.gtp_kchar = k;
    if (exp_v) sb_q.push_back('{data: exp_w, cyc: cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(KIDLE, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic clear_counters();
    @(negedge clk);
    lane_if.gtp_dat = KIDLE; lane_if.gtp_kchar = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    lane_if.gtp_dat = KIDLE; lane_if.gtp_kchar = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (lane_if.vld_o !== 1'b0 || lane_if.dat_o !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out: vld=%b dat=%h, required 0/0000", lane_if.vld_o, lane_if.dat_o);
    end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd0, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL reset_cnt: ok=%0d bad=%0d stray=%0d, required 0/0/0", cnt_ok, cnt_bad, cnt_stray);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    clear_counters();
    send(16'h8403, 1'b0, 1'b1, 16'h8403);
    send(KIDLE,    1'b1, 1'b0, 16'h0000);
    send(16'h0001, 1'b0, 1'b1, 16'h0001);
    send(16'h0002, 1'b0, 1'b1, 16'h0002);
    send(KIDLE,    1'b1, 1'b0, 16'h0000);
    send(KIDLE,    1'b1, 1'b0, 16'h0000);
    send(16'h0004, 1'b0, 1'b1, 16'h0004);
    send(16'h8404, 1'b0, 1'b1, 16'hC003);
    idle(3);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL good_missing: %0d words outstanding, required 0", sb_q.size()); sb_q.delete(); end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd1, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL good_cnt: ok=%0d bad=%0d stray=%0d, required 1/0/0", cnt_ok, cnt_bad, cnt_stray);
    end
  endtask

  task automatic test_bad_csum();
    clear_counters();
    send(16'h8403, 1'b0, 1'b1, 16'h8403);
    send(16'h0001, 1'b0, 1'b1, 16'h0001);
    send(16'h0002, 1'b0, 1'b1, 16'h0002);
    send(16'h0004, 1'b0, 1'b1, 16'h0004);
    send(16'h0000, 1'b0, 1'b1, 16'hE003);
    idle(3);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL csum_missing: %0d words outstanding, required 0", sb_q.size()); sb_q.delete(); end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd0, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL csum_cnt: ok=%0d bad=%0d stray=%0d, required 0/1/0", cnt_ok, cnt_bad, cnt_stray);
    end
  endtask

  task automatic test_truncation();
    clear_counters();
    send(16'h8403, 1'b0, 1'b1, 16'h8403);
    send(16'h0001, 1'b0, 1'b1, 16'h0001);
    send(16'h8802, 1'b0, 1'b1, 16'hD001);
    send(16'h0005, 1'b0, 1'b0, 16'h0000);
    send(16'h0006, 1'b0, 1'b0, 16'h0000);
    idle(3);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL trunc_missing: %0d words outstanding, required 0", sb_q.size()); sb_q.delete(); end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd0, 16'd1, 16'd2}) begin
      n_fail++; $display("FAIL trunc_cnt: ok=%0d bad=%0d stray=%0d, required 0/1/2", cnt_ok, cnt_bad, cnt_stray);
    end
  endtask

  task automatic test_bit15_zero_len();
    clear_counters();
    send(16'h8401, 1'b0, 1'b1, 16'h8401);
    send(16'hC005, 1'b0, 1'b1, 16'h4005);
    send(16'h4404, 1'b0, 1'b1, 16'hC801);
    send(16'h8000, 1'b0, 1'b1, 16'h8000);
    send(16'h8000, 1'b0, 1'b1, 16'hC000);
    idle(3);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL b15_missing: %0d words outstanding, required 0", sb_q.size()); sb_q.delete(); end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd1, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL b15_cnt: ok=%0d bad=%0d stray=%0d, required 1/1/0", cnt_ok, cnt_bad, cnt_stray);
    end
  endtask

  task automatic test_oversize();
    logic [15:0] x;
    clear_counters();
    send(16'h8011, 1'b0, 1'b0, 16'h0000);
    idle(2);
    // Exactly MAXLEN payload words is still accepted.
    x = 16'h8010;
    send(16'h8010, 1'b0, 1'b1, 16'h8010);
    for (int i = 1; i <= MAXLEN; i++) begin
      send(16'(i * 3), 1'b0, 1'b1, 16'(i * 3));
      x = x ^ 16'(i * 3);
    end
    send(x, 1'b0, 1'b1, 16'hC010);
    idle(3);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL over_missing: %0d words outstanding, required 0", sb_q.size()); sb_q.delete(); end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd1, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL over_cnt: ok=%0d bad=%0d stray=%0d, required 1/1/0", cnt_ok, cnt_bad, cnt_stray);
    end
  endtask

  task automatic test_saturation_clear();
    clear_counters();
    for (int i = 0; i < 65536; i++) send(16'h0001, 1'b0, 1'b0, 16'h0000);
    idle(2);
    n_checks++;
    if (cnt_stray !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: stray=%h, required ffff", cnt_stray); end
    send(16'h0002, 1'b0, 1'b0, 16'h0000);
    idle(2);
    n_checks++;
    if (cnt_stray !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: stray=%h, required ffff", cnt_stray); end
    @(negedge clk);
    lane_if.gtp_dat = 16'h0003; lane_if.gtp_kchar = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd0, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL clr_prio: ok=%0d bad=%0d stray=%0d, required 0/0/0", cnt_ok, cnt_bad, cnt_stray);
    end
    cnt_clr = 1'b0; lane_if.gtp_dat = KIDLE; lane_if.gtp_kchar = 1'b1;
  endtask

  task automatic test_async_reset();
    clear_counters();
    send(16'h8403, 1'b0, 1'b1, 16'h8403);
    send(16'h0001, 1'b0, 1'b1, 16'h0001);
    send(16'h0002, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    n_checks++;
    if (lane_if.vld_o !== 1'b1 || lane_if.dat_o !== 16'h0002) begin
      n_fail++; $display("FAIL arst_pre: vld=%b dat=%h, required 1/0002", lane_if.vld_o, lane_if.dat_o);
    end
    rst = 1'b1; lane_if.gtp_dat = KIDLE; lane_if.gtp_kchar = 1'b1;
    #1;
    n_checks++;
    if (lane_if.vld_o !== 1'b0 || lane_if.dat_o !== 16'h0000) begin
      n_fail++; $display("FAIL arst_now: vld=%b dat=%h, required 0/0000", lane_if.vld_o, lane_if.dat_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(16'h0003, 1'b0, 1'b0, 16'h0000);
    send(16'h0004, 1'b0, 1'b0, 16'h0000);
    idle(3);
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd0, 16'd0, 16'd2}) begin
      n_fail++; $display("FAIL arst_stray: ok=%0d bad=%0d stray=%0d, required 0/0/2", cnt_ok, cnt_bad, cnt_stray);
    end
    send(16'h8000, 1'b0, 1'b1, 16'h8000);
    send(16'h8000, 1'b0, 1'b1, 16'hC000);
    idle(3);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL arst_missing: %0d words outstanding, required 0", sb_q.size()); sb_q.delete(); end
    n_checks++;
    if ({cnt_ok, cnt_bad, cnt_stray} !== {16'd1, 16'd0, 16'd2}) begin
      n_fail++; $display("FAIL arst_recover: ok=%0d bad=%0d stray=%0d, required 1/0/2", cnt_ok, cnt_bad, cnt_stray);
    end
  endtask

  initial begin
    lane_if.gtp_dat   = KIDLE;
    lane_if.gtp_kchar = 1'b1;
    // Output monitor: every valid word must match the head of the scoreboard
    // in both value and arrival cycle.
    fork
      forever begin
        @(negedge clk);
        if (lane_if.vld_o === 1'b1) begin
          exp_t e;
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got %h at cycle %0d, required no output", lane_if.dat_o, cyc);
          end else begin
            e = sb_q.pop_front();
            if (lane_if.dat_o !== e.data || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL out_word: got %h at cycle %0d, required %h at cycle %0d", lane_if.dat_o, cyc, e.data, e.cyc);
            end
          end
        end
      end
    join_none
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_truncation();
    test_bit15_zero_len();
    test_oversize();
    test_saturation_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
